// File: rtl/axis_demux_1to2.sv
// Registered 1-to-2 AXI-stream demultiplexer with per-packet route locking.
// Each output has its own register stage; the input stalls only on the output it is routed to.
module axis_demux_1to2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             last,
  output logic             ready,
  output logic [WIDTH-1:0] data_0,
  output logic             valid_0,
  output logic             last_0,
  input  logic             ready_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_1,
  output logic             last_1,
  input  logic             ready_1
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   route;
  logic   route_next;
  logic   eff_route;
  logic   free_0;
  logic   free_1;
  logic   accept;
  logic   load_0;
  logic   load_1;

  // Route selection, input handshake and next-state logic
  always_comb begin
    state_next = state;
    route_next = route;
    eff_route  = (state == BUSY) ? route : sel;
    free_0     = !valid_0 || ready_0;
    free_1     = !valid_1 || ready_1;
    ready      = !rst && (eff_route ? free_1 : free_0);
    accept     = valid && ready;
    load_0     = accept && !eff_route;
    load_1     = accept && eff_route;
    if (accept) begin
      case (state)
        IDLE: begin
          // single-beat packets never open a packet, so route stays untouched
          if (!last) begin
            route_next = sel;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (last) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  // Route FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      route <= 1'b0;
    end else begin
      state <= state_next;
      route <= route_next;
    end
  end

  // Output register 0: load wins over drain so valid stays high on a simultaneous refill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_0 <= 1'b0;
      data_0  <= '0;
      last_0  <= 1'b0;
    end else if (load_0) begin
      valid_0 <= 1'b1;
      data_0  <= data;
      last_0  <= last;
    end else if (ready_0) begin
      valid_0 <= 1'b0;
    end
  end

  // Output register 1
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_1 <= 1'b0;
      data_1  <= '0;
      last_1  <= 1'b0;
    end else if (load_1) begin
      valid_1 <= 1'b1;
      data_1  <= data;
      last_1  <= last;
    end else if (ready_1) begin
      valid_1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_demux_1to2.sv
// Bench for axis_demux_1to2: directed scenarios plus a per-output scoreboard
// fed from a reference route model at input acceptance.
module tb_axis_demux_1to2;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             sel;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;
  logic [WIDTH-1:0] data_0;
  logic             valid_0;
  logic             last_0;
  logic             ready_0;
  logic [WIDTH-1:0] data_1;
  logic             valid_1;
  logic             last_1;
  logic             ready_1;

  int n_checks = 0;
  int n_pass   = 0;

  logic rand_rdy = 1'b0;
  logic dir0     = 1'b1;
  logic dir1     = 1'b1;
  logic rnd0     = 1'b1;
  logic rnd1     = 1'b1;

  assign ready_0 = rand_rdy ? rnd0 : dir0;
  assign ready_1 = rand_rdy ? rnd1 : dir1;

  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  logic           busy_m  = 1'b0;
  logic           route_m = 1'b0;

  axis_demux_1to2 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .data   (data),
    .valid  (valid),
    .last   (last),
    .ready  (ready),
    .data_0 (data_0),
    .valid_0(valid_0),
    .last_0 (last_0),
    .ready_0(ready_0),
    .data_1 (data_1),
    .valid_1(valid_1),
    .last_1 (last_1),
    .ready_1(ready_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Random consumer back-pressure, updated just after each rising edge
  always begin
    @(posedge clk);
    #1;
    rnd0 = ($urandom_range(0, 3) != 0);
    rnd1 = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: compare drained beats, then enqueue newly accepted beats by model route
  always @(negedge clk) begin
    logic [WIDTH:0] exp_beat;
    logic           r;
    if (rst) begin
      q0.delete();
      q1.delete();
      busy_m  = 1'b0;
      route_m = 1'b0;
    end else begin
      if (valid_0 && ready_0) begin
        if (q0.size() == 0) check("out0_unexpected", {15'd0, last_0, data_0}, 32'hFFFF_FFFF);
        else begin
          exp_beat = q0.pop_front();
          check("out0_beat", {15'd0, last_0, data_0}, {15'd0, exp_beat});
        end
      end
      if (valid_1 && ready_1) begin
        if (q1.size() == 0) check("out1_unexpected", {15'd0, last_1, data_1}, 32'hFFFF_FFFF);
        else begin
          exp_beat = q1.pop_front();
          check("out1_beat", {15'd0, last_1, data_1}, {15'd0, exp_beat});
        end
      end
      if (ready_0 && ready_1) check("tput_ready", 32'(ready), 32'd1);
      if (valid && ready) begin
        r = busy_m ? route_m : sel;
        if (r) q1.push_back({last, data});
        else   q0.push_back({last, data});
        if (!busy_m && !last) begin
          busy_m  = 1'b1;
          route_m = sel;
        end else if (busy_m && last) begin
          busy_m = 1'b0;
        end
      end
    end
  end

  // Present one beat and return just after the edge that accepts it
  task automatic send(input logic s, input logic [WIDTH-1:0] d, input logic l);
    logic got;
    got   = 1'b0;
    sel   = s;
    data  = d;
    last  = l;
    valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int len;
    rst   = 1'b1;
    sel   = 1'b0;
    data  = '0;
    valid = 1'b0;
    last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", {30'd0, valid_1, valid_0}, 32'd0);
    check("rst_data", {data_1, data_0}, 32'd0);
    check("rst_last", {30'd0, last_1, last_0}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single-beat routing to each output
    send(1'b0, 16'hA5A5, 1'b1);
    check("t1_valid0", 32'(valid_0), 32'd1);
    check("t1_data0", 32'(data_0), 32'h0000_A5A5);
    check("t1_valid1", 32'(valid_1), 32'd0);
    send(1'b1, 16'h1234, 1'b1);
    check("t1_valid1b", 32'(valid_1), 32'd1);
    check("t1_data1", 32'(data_1), 32'h0000_1234);
    check("t1_valid0b", 32'(valid_0), 32'd0);
    idle(3);

    // Route lock while sel toggles every beat
    for (int k = 1; k <= 4; k++) begin
      send(k[0], 16'(k), (k == 4));
      check("t2_valid1", 32'(valid_1), 32'd1);
      check("t2_data1", 32'(data_1), 32'(k));
      check("t2_last1", 32'(last_1), (k == 4) ? 32'd1 : 32'd0);
      check("t2_valid0", 32'(valid_0), 32'd0);
    end
    idle(3);

    // Back-pressure on output 0
    dir0 = 1'b0;
    send(1'b0, 16'h0011, 1'b0);
    check("t3_hold_valid", 32'(valid_0), 32'd1);
    sel   = 1'b1;
    data  = 16'h0022;
    last  = 1'b0;
    valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_low", 32'(ready), 32'd0);
      check("t3_hold_data", 32'(data_0), 32'h0000_0011);
    end
    @(posedge clk);
    #1;
    dir0 = 1'b1;
    send(1'b1, 16'h0022, 1'b0);
    check("t3_b2", {15'd0, last_0, data_0}, 32'h0000_0022);
    send(1'b1, 16'h0033, 1'b1);
    check("t3_b3", {15'd0, last_0, data_0}, 32'h0001_0033);
    idle(3);

    // Stalled output 0 does not block a packet to output 1
    dir0 = 1'b0;
    send(1'b0, 16'h0055, 1'b1);
    sel   = 1'b1;
    data  = 16'h0066;
    last  = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    check("t4_ready", 32'(ready), 32'd1);
    send(1'b1, 16'h0066, 1'b1);
    check("t4_out1", {15'd0, valid_1, data_1}, 32'h0001_0066);
    check("t4_out0", {15'd0, valid_0, data_0}, 32'h0001_0055);
    dir0 = 1'b1;
    idle(3);

    // Reset in the middle of a packet to output 1
    send(1'b1, 16'h00B1, 1'b0);
    send(1'b1, 16'h00B2, 1'b0);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("t5_ready_rst", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("t5_valids", {30'd0, valid_1, valid_0}, 32'd0);
    check("t5_data", {data_1, data_0}, 32'd0);
    rst = 1'b0;
    send(1'b0, 16'h00C0, 1'b1);
    check("t5_out0", {15'd0, valid_0, data_0}, 32'h0001_00C0);
    check("t5_valid1", 32'(valid_1), 32'd0);
    idle(3);

    // Random packets: first 30 with consumers always ready, then random stalls
    for (int p = 0; p < 100; p++) begin
      if (p == 30) rand_rdy = 1'b1;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if (p >= 30 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(1'(($urandom_range(0, 1))), 16'($urandom), (b == len - 1));
      end
    end
    valid    = 1'b0;
    rand_rdy = 1'b0;
    dir0     = 1'b1;
    dir1     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    #1;
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("end_busy_model", 32'(busy_m), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
